vga_timing_generator: RTL
=========================

Name: vga_timing_generator

Overview:
Produces the 640x480@60 Hz raster timing that drives the pixel-colour logic: column/row coordinates, display_enable, and the horizontal/vertical sync outputs to the connector. It also emits per-frame strobes so game-state logic (Mario/Goomba motion, countdown clock) can update once per frame during vertical blanking. It sits between the clock divider and the VGA pixel logic; its row, column and display_enable outputs feed that logic directly.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE_LOW, 1, 1 = sync pulses are driven low while active

Ports:
vga_clock  input  1  pixel-domain clock
reset  input  1  asynchronous, active-low reset
pixel_tick  input  1  clock enable; counters advance only on cycles where it is 1
column  output  int  horizontal counter, 0..H_TOTAL-1
row  output  int  vertical counter, 0..V_TOTAL-1
display_enable  output  1  high when column < H_VISIBLE and row < V_VISIBLE
vga_hsync  output  1  horizontal sync
vga_vsync  output  1  vertical sync
line_start  output  1  one-cycle pulse when column wraps to 0
frame_done  output  1  one-cycle pulse on entering (row = V_VISIBLE, column = 0)
frame_count  output  int  frames completed since reset, wraps at 2^32

Behaviour:
- Derived constants: H_TOTAL = sum of the H_* parameters (800 by default); V_TOTAL = sum of the V_* parameters (525 by default).
- State is held in registered h_count, v_count and frame_count. All outputs are registered or decoded only from registers, so every output reflects the same (h, v) pair in the same cycle and there is no skew.
- Reset (reset = 0, asynchronous):
  - h_count = v_count = 0, frame_count = 0.
  - line_start = frame_done = 0.
  - Sync outputs are inactive (1 when SYNC_ACTIVE_LOW = 1).
  - display_enable = 1 because (0,0) is visible.
- Advance rules, applied only on a rising edge with pixel_tick = 1:
  - Horizontal: if h_count == H_TOTAL-1, then h_count := 0; otherwise h_count increments.
  - Vertical, only when h wraps: if v_count == V_TOTAL-1, then v_count := 0 and frame_count increments (modulo 2^32); otherwise v_count increments.
- pixel_tick = 0: every counter and every level output holds its value. line_start and frame_done are forced to 0 on that cycle, so each strobe lasts exactly one tick-qualified cycle.
- Outputs:
  - column = h_count; row = v_count.
  - hsync is active when H_VISIBLE+H_FRONT <= h_count < H_VISIBLE+H_FRONT+H_SYNC (656..751 by default).
  - vsync is active when V_VISIBLE+V_FRONT <= v_count < V_VISIBLE+V_FRONT+V_SYNC (490..491 by default). vsync changes only at h_count = 0.
  - line_start = 1 on the cycle where h_count == 0 after an advance.
  - frame_done = 1 on the cycle where (h, v) == (0, V_VISIBLE) after an advance. It fires exactly once per frame and precedes the frame_count increment by 45 lines.
- Width rules: counters are compared as unsigned. Parameters must give H_TOTAL and V_TOTAL values below 2^16. This is checked by an elaboration-time assertion.
- Reset released mid-frame: the raster restarts at (0,0) with no partial strobes. The first line_start after reset fires when h wraps from H_TOTAL-1, not at release.
- A pixel_tick held permanently high gives the standard 25 MHz timing when vga_clock is 25 MHz.

Decomposition:
- Package vga_timing_pkg holds:
  - the default timing constants;
  - derived H_TOTAL and V_TOTAL;
  - the sync-window start and end constants;
  - a typedef struct { int row; int column; logic display_enable; }, reused by the pixel logic.
- One sub-module, vga_axis_counter (parameters: TOTAL, SYNC_START, SYNC_END). It provides a wrapping counter with enable, wrap output, and in-sync decode. It is instantiated once for horizontal and once for vertical, with the vertical enable = horizontal wrap & pixel_tick.

Test Plan:
- Reset, then 1 tick: row = 0, column = 1, display_enable = 1, hsync = 1, vsync = 1, frame_count = 0.
- 656 ticks from (0,0): hsync falls on the cycle column = 656, rises at column = 752. display_enable falls at column = 640.
- Run to column = 799 and tick once: column = 0, row = 1, line_start = 1 for exactly one cycle.
- Run to (0,480): frame_done = 1 for one cycle and display_enable = 0. vsync is low for rows 490–491 (1600 ticks), then high.
- Run a full 420000-tick frame: position returns to (0,0), frame_count = 1. Repeat three frames: frame_count = 3, with exactly 3 frame_done pulses and 1575 line_start pulses.
- Hold pixel_tick = 0 for 7 cycles at (100,200): outputs are frozen and no strobes occur. Then assert reset asynchronously mid-cycle: outputs are immediately at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz timing constants and the raster position bundle
// used by the timing generator and the pixel-colour logic.
package vga_timing_pkg;

    localparam int H_VISIBLE_D = 640;
    localparam int H_FRONT_D   = 16;
    localparam int H_SYNC_D    = 96;
    localparam int H_BACK_D    = 48;
    localparam int V_VISIBLE_D = 480;
    localparam int V_FRONT_D   = 10;
    localparam int V_SYNC_D    = 2;
    localparam int V_BACK_D    = 33;

    localparam int H_TOTAL_D =
        H_VISIBLE_D + H_FRONT_D + H_SYNC_D + H_BACK_D;
    localparam int V_TOTAL_D =
        V_VISIBLE_D + V_FRONT_D + V_SYNC_D + V_BACK_D;

    localparam int H_SYNC_START_D = H_VISIBLE_D + H_FRONT_D;
    localparam int H_SYNC_END_D   = H_SYNC_START_D + H_SYNC_D;
    localparam int V_SYNC_START_D = V_VISIBLE_D + V_FRONT_D;
    localparam int V_SYNC_END_D   = V_SYNC_START_D + V_SYNC_D;

    typedef struct packed {
        int   row;
        int   column;
        logic display_enable;
    } vga_pos_t;

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping raster counter for one axis, with wrap strobe and
// sync-window decode taken straight from the count register.
import vga_timing_pkg::*;

module vga_axis_counter #(
    parameter int TOTAL      = H_TOTAL_D,
    parameter int SYNC_START = H_SYNC_START_D,
    parameter int SYNC_END   = H_SYNC_END_D
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] count,
    output logic        wrap,
    output logic        in_sync
);

    localparam logic [15:0] LAST = 16'(TOTAL - 1);
    localparam logic [15:0] S_LO = 16'(SYNC_START);
    localparam logic [15:0] S_HI = 16'(SYNC_END);

    assign wrap    = en && (count == LAST);
    assign in_sync = (count >= S_LO) && (count < S_HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 16'd1;
        end
    end

endmodule

// File: rtl/vga_timing_generator.sv
// Raster timing for the VGA pixel logic: coordinates, blanking,
// sync pulses and line/frame strobes for once-per-frame game updates.
import vga_timing_pkg::*;

module vga_timing_generator #(
    parameter int H_VISIBLE       = H_VISIBLE_D,
    parameter int H_FRONT         = H_FRONT_D,
    parameter int H_SYNC          = H_SYNC_D,
    parameter int H_BACK          = H_BACK_D,
    parameter int V_VISIBLE       = V_VISIBLE_D,
    parameter int V_FRONT         = V_FRONT_D,
    parameter int V_SYNC          = V_SYNC_D,
    parameter int V_BACK          = V_BACK_D,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic vga_clock,
    input  logic reset,
    input  logic pixel_tick,
    output int   column,
    output int   row,
    output logic display_enable,
    output logic vga_hsync,
    output logic vga_vsync,
    output logic line_start,
    output logic frame_done,
    output int   frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [15:0] H_VIS = 16'(H_VISIBLE);
    localparam logic [15:0] V_VIS = 16'(V_VISIBLE);
    localparam logic [15:0] V_PRE = 16'(V_VISIBLE - 1);

    if (H_TOTAL >= 65536 || V_TOTAL >= 65536) begin : g_range_check
        $error("vga_timing_generator: H_TOTAL/V_TOTAL must be < 2^16");
    end

    logic [15:0] h_count;
    logic [15:0] v_count;
    logic        h_wrap;
    logic        v_wrap;
    logic        h_in_sync;
    logic        v_in_sync;
    vga_pos_t    pos;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .SYNC_START (H_VISIBLE + H_FRONT),
        .SYNC_END   (H_VISIBLE + H_FRONT + H_SYNC)
    ) u_h (
        .clk     (vga_clock),
        .rst_n   (reset),
        .en      (pixel_tick),
        .count   (h_count),
        .wrap    (h_wrap),
        .in_sync (h_in_sync)
    );

    // Vertical steps only on the tick-qualified horizontal wrap.
    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .SYNC_START (V_VISIBLE + V_FRONT),
        .SYNC_END   (V_VISIBLE + V_FRONT + V_SYNC)
    ) u_v (
        .clk     (vga_clock),
        .rst_n   (reset),
        .en      (h_wrap),
        .count   (v_count),
        .wrap    (v_wrap),
        .in_sync (v_in_sync)
    );

    // Strobes are registered against the next position so they align
    // with the (h, v) pair that the counters are about to hold.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            line_start  <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 0;
        end else begin
            line_start <= h_wrap;
            frame_done <= h_wrap && (v_count == V_PRE);
            if (v_wrap) begin
                frame_count <= frame_count + 1;
            end
        end
    end

    assign pos.column         = {16'd0, h_count};
    assign pos.row            = {16'd0, v_count};
    assign pos.display_enable = (h_count < H_VIS) && (v_count < V_VIS);

    assign column         = pos.column;
    assign row            = pos.row;
    assign display_enable = pos.display_enable;
    assign vga_hsync      = SYNC_ACTIVE_LOW ? ~h_in_sync : h_in_sync;
    assign vga_vsync      = SYNC_ACTIVE_LOW ? ~v_in_sync : v_in_sync;

endmodule
